// File: rtl/house_state_ctrl_pkg.sv
// Shared types and constants for the house tile controller.
package house_pkg;

    typedef enum logic [2:0] {
        ALIVE      = 3'd0,
        HIT_FLASH  = 3'd1,
        SHIELDED   = 3'd2,
        DESTROYING = 3'd3,
        DEAD       = 3'd4
    } house_state_t;

    localparam logic [7:0] HOUSE_COLOR_DEF      = 8'h00;
    localparam logic [7:0] FLASH_COLOR_DEF      = 8'hF0;
    localparam logic [7:0] SHIELD_COLOR_DEF     = 8'h1C;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/house_state_ctrl_if.sv
// Signals between the house controller and its neighbours (collision, power-up, drawer).
interface house_state_ctrl_if;
    logic       startOfFrame;
    logic       hitPulse;
    logic       shieldReq;
    logic       newGame;
    logic       houseEnable;
    logic [7:0] houseColor;
    logic [2:0] hitsLeft;
    logic       gameOver;
    logic [2:0] stateOut;

    modport master (
        output startOfFrame, hitPulse, shieldReq, newGame,
        input  houseEnable, houseColor, hitsLeft, gameOver, stateOut
    );

    modport slave (
        input  startOfFrame, hitPulse, shieldReq, newGame,
        output houseEnable, houseColor, hitsLeft, gameOver, stateOut
    );
endinterface

// File: rtl/house_state_ctrl_frame_timer.sv
// Saturating frame counter plus blink phase, shared by every timed house state.
module frame_timer #(
    parameter int MAX_COUNT    = 120,
    parameter int BLINK_PERIOD = 4,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count_adv,
    output logic             o_phase_adv
);

    localparam int BLK_W = $clog2(BLINK_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIOD - 1);

    logic [CNT_W-1:0] r_count;
    logic [BLK_W-1:0] r_blink;
    logic             r_phase;
    logic [BLK_W-1:0] w_blink_adv;

    // The *_adv values include this cycle's tick but not the clear, so the
    // owner can compare against them without a combinational loop.
    always_comb begin
        o_count_adv = r_count;
        w_blink_adv = r_blink;
        o_phase_adv = r_phase;
        if (i_tick) begin
            if (r_count != CNT_MAX)
                o_count_adv = r_count + CNT_W'(1);
            if (r_blink == BLK_LAST) begin
                w_blink_adv = '0;
                o_phase_adv = ~r_phase;
            end else begin
                w_blink_adv = r_blink + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else begin
            r_count <= o_count_adv;
            r_blink <= w_blink_adv;
            r_phase <= o_phase_adv;
        end
    end

endmodule

// File: rtl/house_state_ctrl.sv
// House tile controller: hit points, hit-flash / shield / destruction sequencing,
// drawer enable and colour, and game-over.
module house_state_ctrl
    import house_pkg::*;
#(
    parameter int         MAX_HITS       = 3,
    parameter int         FLASH_FRAMES   = 16,
    parameter int         SHIELD_FRAMES  = 120,
    parameter int         DESTROY_FRAMES = 60,
    parameter int         BLINK_PERIOD   = 4,
    parameter logic [7:0] HOUSE_COLOR    = HOUSE_COLOR_DEF,
    parameter logic [7:0] FLASH_COLOR    = FLASH_COLOR_DEF,
    parameter logic [7:0] SHIELD_COLOR   = SHIELD_COLOR_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    house_state_ctrl_if.slave  bus
);

    localparam int CNT_MAX = max3(FLASH_FRAMES, SHIELD_FRAMES, DESTROY_FRAMES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLASH_CNT   = CNT_W'(FLASH_FRAMES);
    localparam logic [CNT_W-1:0] SHIELD_CNT  = CNT_W'(SHIELD_FRAMES);
    localparam logic [CNT_W-1:0] DESTROY_CNT = CNT_W'(DESTROY_FRAMES);
    localparam logic [2:0]       HITS_INIT   = 3'(MAX_HITS);

    house_state_t     r_state, w_state_next;
    logic [2:0]       r_hits, w_hits_next;
    logic             r_hit_prev, r_hit_latched, w_hit_latched_next;
    logic             w_hit_rise, w_hit_qual;
    logic             w_shield_reload, w_timer_clear;
    logic [CNT_W-1:0] w_count_adv;
    logic             w_phase_adv, w_phase_next;
    logic             r_enable, w_enable_next;
    logic [7:0]       r_color, w_color_next;
    logic             r_game_over, w_game_over_next;

    frame_timer #(
        .MAX_COUNT   (CNT_MAX),
        .BLINK_PERIOD(BLINK_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .i_tick     (bus.startOfFrame),
        .i_clear    (w_timer_clear),
        .o_count_adv(w_count_adv),
        .o_phase_adv(w_phase_adv)
    );

    // A rise coinciding with startOfFrame belongs to the new frame and always counts.
    assign w_hit_rise = bus.hitPulse & ~r_hit_prev;
    assign w_hit_qual = w_hit_rise & (~r_hit_latched | bus.startOfFrame);

    always_comb begin
        w_hit_latched_next = r_hit_latched;
        if (bus.newGame)
            w_hit_latched_next = 1'b0;
        else if (w_hit_qual)
            w_hit_latched_next = 1'b1;
        else if (bus.startOfFrame)
            w_hit_latched_next = 1'b0;
    end

    always_comb begin
        w_state_next    = r_state;
        w_hits_next     = r_hits;
        w_shield_reload = 1'b0;
        if (bus.newGame) begin
            w_state_next = ALIVE;
            w_hits_next  = HITS_INIT;
        end else begin
            unique case (r_state)
                ALIVE: begin
                    if (w_hit_qual) begin
                        if (r_hits > 3'd1) begin
                            w_state_next = HIT_FLASH;
                            w_hits_next  = r_hits - 3'd1;
                        end else begin
                            w_state_next = DESTROYING;
                            w_hits_next  = 3'd0;
                        end
                    end else if (bus.shieldReq) begin
                        w_state_next = SHIELDED;
                    end
                end
                HIT_FLASH: begin
                    if (w_count_adv == FLASH_CNT)
                        w_state_next = ALIVE;
                end
                SHIELDED: begin
                    if (bus.shieldReq)
                        w_shield_reload = 1'b1;
                    else if (w_count_adv == SHIELD_CNT)
                        w_state_next = ALIVE;
                end
                DESTROYING: begin
                    if (w_count_adv == DESTROY_CNT)
                        w_state_next = DEAD;
                end
                DEAD: begin
                    w_hits_next = 3'd0;
                end
                default: begin
                    w_state_next = ALIVE;
                    w_hits_next  = HITS_INIT;
                end
            endcase
        end
    end

    assign w_timer_clear = bus.newGame | w_shield_reload | (w_state_next != r_state);
    assign w_phase_next  = w_timer_clear ? 1'b0 : w_phase_adv;

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        w_enable_next    = 1'b1;
        w_color_next     = HOUSE_COLOR;
        w_game_over_next = 1'b0;
        unique case (w_state_next)
            HIT_FLASH:  w_color_next  = w_phase_next ? HOUSE_COLOR : FLASH_COLOR;
            SHIELDED:   w_color_next  = SHIELD_COLOR;
            DESTROYING: w_enable_next = w_phase_next;
            DEAD: begin
                w_enable_next    = 1'b0;
                w_game_over_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ALIVE;
            r_hits        <= HITS_INIT;
            r_hit_prev    <= 1'b0;
            r_hit_latched <= 1'b0;
            r_enable      <= 1'b1;
            r_color       <= HOUSE_COLOR;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hits        <= w_hits_next;
            r_hit_prev    <= bus.hitPulse;
            r_hit_latched <= w_hit_latched_next;
            r_enable      <= w_enable_next;
            r_color       <= w_color_next;
            r_game_over   <= w_game_over_next;
        end
    end

    assign bus.stateOut    = r_state;
    assign bus.hitsLeft    = r_hits;
    assign bus.houseEnable = r_enable;
    assign bus.houseColor  = r_color;
    assign bus.gameOver    = r_game_over;

endmodule

// File: tb/tb_house_state_ctrl.sv
// Directed bench for house_state_ctrl: vector table plus multi-frame sequences.
module tb_house_state_ctrl;
    import house_pkg::*;

    localparam int FL = 20;  // clock cycles per frame

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    house_state_ctrl_if bus();

    house_state_ctrl dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit         sof, hit, shd, ng;
        int         st, hits;
        bit         en;
        logic [7:0] col;
        bit         go;
    } vec_t;

    vec_t vecs[15];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        cyc();
        bus.startOfFrame = 1'b0;
        repeat (FL - 1) cyc();
    endtask

    task automatic hit_pulse();
        bus.hitPulse = 1'b1;
        cyc();
        bus.hitPulse = 1'b0;
    endtask

    task automatic shield_pulse();
        bus.shieldReq = 1'b1;
        cyc();
        bus.shieldReq = 1'b0;
    endtask

    task automatic ng_pulse();
        bus.newGame = 1'b1;
        cyc();
        bus.newGame = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    endtask

    task automatic chk_all(input string tag, input int st, input int hits,
                           input int en, input int col, input int go);
        chk({tag, " state"},  int'(bus.stateOut),    st);
        chk({tag, " hits"},   int'(bus.hitsLeft),    hits);
        chk({tag, " enable"}, int'(bus.houseEnable), en);
        chk({tag, " color"},  int'(bus.houseColor),  col);
        chk({tag, " over"},   int'(bus.gameOver),    go);
    endtask

    initial begin
        //           sof hit shd ng  st hits en col    go
        vecs[0]  = '{0, 0, 0, 0, 0, 3, 1, 8'h00, 0};
        vecs[1]  = '{0, 1, 1, 0, 1, 2, 1, 8'hF0, 0};  // hit beats shield
        vecs[2]  = '{0, 1, 1, 0, 1, 2, 1, 8'hF0, 0};
        vecs[3]  = '{1, 0, 0, 0, 1, 2, 1, 8'hF0, 0};
        vecs[4]  = '{0, 1, 0, 0, 1, 2, 1, 8'hF0, 0};  // ignored in flash
        vecs[5]  = '{0, 0, 0, 1, 0, 3, 1, 8'h00, 0};
        vecs[6]  = '{0, 0, 1, 0, 2, 3, 1, 8'h1C, 0};
        vecs[7]  = '{0, 1, 0, 0, 2, 3, 1, 8'h1C, 0};  // ignored while shielded
        vecs[8]  = '{0, 0, 0, 1, 0, 3, 1, 8'h00, 0};
        vecs[9]  = '{0, 1, 0, 1, 0, 3, 1, 8'h00, 0};  // newGame beats hit
        vecs[10] = '{0, 0, 0, 0, 0, 3, 1, 8'h00, 0};
        vecs[11] = '{1, 1, 0, 0, 1, 2, 1, 8'hF0, 0};  // hit on frame start counts
        vecs[12] = '{0, 0, 0, 1, 0, 3, 1, 8'h00, 0};
        vecs[13] = '{0, 1, 0, 0, 1, 2, 1, 8'hF0, 0};
        vecs[14] = '{0, 0, 0, 1, 0, 3, 1, 8'h00, 0};

        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.hitPulse     = 1'b0;
        bus.shieldReq    = 1'b0;
        bus.newGame      = 1'b0;
        repeat (3) cyc();
        chk_all("in reset", 0, 3, 1, 8'h00, 0);
        resetN = 1'b1;

        // Idle after reset
        repeat (5) frame();
        chk_all("t1 idle", 0, 3, 1, 8'h00, 0);
        $display("t1: idle 5 frames, state=%0d hits=%0d", bus.stateOut, bus.hitsLeft);

        for (int i = 0; i < 15; i++) begin
            bus.startOfFrame = vecs[i].sof;
            bus.hitPulse     = vecs[i].hit;
            bus.shieldReq    = vecs[i].shd;
            bus.newGame      = vecs[i].ng;
            cyc();
            $display("vec %0d: state=%0d hits=%0d en=%0b color=%02h over=%0b",
                     i, bus.stateOut, bus.hitsLeft, bus.houseEnable, bus.houseColor, bus.gameOver);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].hits,
                    int'(vecs[i].en), int'(vecs[i].col), int'(vecs[i].go));
        end
        bus.startOfFrame = 1'b0;
        bus.hitPulse     = 1'b0;
        bus.shieldReq    = 1'b0;
        bus.newGame      = 1'b0;
        cyc();

        // Held hit: one decrement, flash pattern, back to ALIVE after 16 frames
        bus.hitPulse = 1'b1;
        cyc();
        chk_all("t2 entry", 1, 2, 1, 8'hF0, 0);
        for (int k = 1; k <= 16; k++) begin
            frame();
            if (k == 9) bus.hitPulse = 1'b0;
            if (k == 10) begin
                hit_pulse();
                chk("t2 rehit hits", int'(bus.hitsLeft), 2);
            end
            if (k < 16) chk_all($sformatf("t2 f%0d", k), 1, 2, 1, ((k / 4) % 2) ? 8'h00 : 8'hF0, 0);
            else        chk_all("t2 done", 0, 2, 1, 8'h00, 0);
        end
        $display("t2: flash done, state=%0d hits=%0d", bus.stateOut, bus.hitsLeft);

        // Shield with extension
        ng_pulse();
        shield_pulse();
        chk_all("t3 entry", 2, 3, 1, 8'h1C, 0);
        for (int k = 1; k <= 220; k++) begin
            frame();
            if (k == 5 || k == 50) begin
                hit_pulse();
                chk_all($sformatf("t3 hit f%0d", k), 2, 3, 1, 8'h1C, 0);
            end
            if (k == 100) shield_pulse();
            if (k == 119) chk("t3 extended state", int'(bus.stateOut), 2);
            if (k == 219) chk("t3 f219 state", int'(bus.stateOut), 2);
            if (k == 220) chk_all("t3 expire", 0, 3, 1, 8'h00, 0);
        end
        $display("t3: shield expired, state=%0d", bus.stateOut);

        // Three hits to destruction, blink, then DEAD
        hit_pulse();
        chk_all("t4 hit1", 1, 2, 1, 8'hF0, 0);
        repeat (17) frame();
        chk("t4 alive1", int'(bus.stateOut), 0);
        hit_pulse();
        chk_all("t4 hit2", 1, 1, 1, 8'hF0, 0);
        repeat (17) frame();
        hit_pulse();
        chk_all("t4 hit3", 3, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 60; k++) begin
            frame();
            if (k < 60) chk($sformatf("t4 blink f%0d", k), int'(bus.houseEnable), (k / 4) % 2);
            else        chk_all("t4 dead", 4, 0, 0, 8'h00, 1);
        end
        hit_pulse();
        shield_pulse();
        chk_all("t4 dead hold", 4, 0, 0, 8'h00, 1);
        $display("t4: dead, over=%0b", bus.gameOver);

        ng_pulse();
        chk_all("t5 newgame", 0, 3, 1, 8'h00, 0);
        $display("t5: new game, state=%0d hits=%0d", bus.stateOut, bus.hitsLeft);

        // Async reset mid-destruction
        hit_pulse();
        repeat (17) frame();
        hit_pulse();
        repeat (17) frame();
        hit_pulse();
        repeat (30) frame();
        chk("t6 destroying", int'(bus.stateOut), 3);
        #2 resetN = 1'b0;
        #1 chk_all("t6 async", 0, 3, 1, 8'h00, 0);
        @(negedge clk);
        resetN = 1'b1;
        cyc();
        hit_pulse();
        chk_all("t6 hit", 1, 2, 1, 8'hF0, 0);
        for (int k = 1; k <= 16; k++) begin
            frame();
            if (k == 3)  chk("t6 f3 color", int'(bus.houseColor), 8'hF0);
            if (k == 4)  chk("t6 f4 color", int'(bus.houseColor), 8'h00);
            if (k == 15) chk("t6 f15 state", int'(bus.stateOut), 1);
            if (k == 16) chk("t6 f16 state", int'(bus.stateOut), 0);
        end
        $display("t6: post-reset flash done, state=%0d", bus.stateOut);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
